// File: rtl/axi_read_responder_pkg.sv
// axi_read_responder_pkg: burst/resp/state types and beat sizing shared by the read responder
package axi_read_responder_pkg;
   localparam int BEAT_BYTES = 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10, BURST_RSVD = 2'b11} burst_e;
   typedef enum logic [1:0] {IDLE, DELAY, BURST} state_e;
endpackage

// File: rtl/axi_read_responder_burst_addr_gen.sv
// axi_burst_addr_gen: byte address of a given beat for FIXED, INCR and WRAP bursts
module axi_burst_addr_gen
   import axi_read_responder_pkg::*;
(
   input  logic [63:0] base,
   input  logic [7:0]  len,
   input  burst_e      burst,
   input  logic [7:0]  beat,
   output logic [63:0] addr
);
   logic [63:0] mask, incr;
   always_comb begin
      mask = 64'(len) * 64'(BEAT_BYTES) + 64'(BEAT_BYTES - 1);
      incr = base + 64'(beat) * 64'(BEAT_BYTES);
      addr = burst == BURST_INCR ? incr : burst == BURST_WRAP ? (base & ~mask) | (incr & mask) : base;
   end
endmodule

// File: rtl/axi_read_responder.sv
// axi_read_responder: single-outstanding AXI4 read slave over a backdoor-loaded 64-bit word memory
module axi_read_responder
   import axi_read_responder_pkg::*;
#(
   parameter int MEM_WORDS        = 4096,
   parameter int FIRST_BEAT_DELAY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [63:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   input  logic        load_en,
   input  logic [63:0] load_addr,
   input  logic [63:0] load_data
);
   localparam int AW = $clog2(MEM_WORDS);
   logic [63:0] mem [MEM_WORDS];
   state_e      state, state_n;
   burst_e      burst_q;
   logic [63:0] addr_q, fetch_addr;
   logic [7:0]  len_q, beat, dcnt, fetch_beat;
   logic [2:0]  size_q;
   logic        bad, fetch, in_range, unused;
   assign s_axi_arready = state == IDLE;
   assign s_axi_rvalid  = state == BURST;
   assign s_axi_rlast   = state == BURST && beat == len_q;
   assign bad           = size_q != 3'd3 || burst_q == BURST_RSVD ||
                          (burst_q == BURST_WRAP && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
   assign fetch_beat    = state == BURST ? beat + 8'd1 : 8'd0;
   assign in_range      = fetch_addr[63:3] < 61'(MEM_WORDS);
   assign unused        = ^fetch_addr[2:0];
   axi_burst_addr_gen u_addr (
      .base  (addr_q),
      .len   (len_q),
      .burst (burst_q),
      .beat  (fetch_beat),
      .addr  (fetch_addr)
   );
   // a beat is fetched into the output register on the edge it becomes (or stays) visible
   always_comb begin
      fetch   = state == DELAY ? dcnt == 8'(FIRST_BEAT_DELAY - 1) : state == BURST && s_axi_rready && !s_axi_rlast;
      state_n = state == IDLE  ? (s_axi_arvalid ? DELAY : IDLE)
              : state == DELAY ? (fetch ? BURST : DELAY)
              : state == BURST ? (s_axi_rready && s_axi_rlast ? IDLE : BURST) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         beat        <= '0;
         dcnt        <= '0;
         s_axi_rdata <= '0;
         s_axi_rresp <= RESP_OKAY;
      end else begin
         state <= state_n;
         dcnt  <= state == DELAY ? dcnt + 8'd1 : 8'd0;
         if (s_axi_arvalid && s_axi_arready) begin
            addr_q  <= s_axi_araddr;
            len_q   <= s_axi_arlen;
            size_q  <= s_axi_arsize;
            burst_q <= burst_e'(s_axi_arburst);
            beat    <= '0;
         end
         if (s_axi_rvalid && s_axi_rready) beat <= beat + 8'd1;
         if (fetch) begin
            s_axi_rdata <= !bad && in_range ? mem[fetch_addr[AW+2:3]] : 64'd0;
            s_axi_rresp <= !bad && in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (load_en && load_addr < 64'(MEM_WORDS)) mem[load_addr[AW-1:0]] <= load_data;
   end
endmodule
